md_sched: RTL
=============

# md_sched

Multi-cycle multiply/divide scheduler for the E stage of the five-stage pipelined CPU. It decodes SPECIAL-class HI/LO instructions held in E, launches a fixed-latency multiply or divide, and holds a busy interval. It owns the HI/LO registers and returns mfhi/mflo data to the E-stage result path. It also asserts the D-stage stall when a HI/LO instruction would enter E while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- E_op  in  6  opcode of the instruction in E
- E_fuc  in  6  funct field of the instruction in E
- E_RS  in  32  forwarded rs operand in E
- E_RT  in  32  forwarded rt operand in E
- D_md  in  1  instruction in D is any of the 8 HI/LO instructions
- E_MD_start  out  1  combinational; mult/multu/div/divu in E while idle
- E_MD_busy  out  1  registered; operation in flight
- E_MD_out  out  32  combinational; HI for mfhi, LO for mflo, else 0
- D_MD_stall  out  1  combinational; D_md & (E_MD_start | E_MD_busy)
- HI, LO  out  32 each  architectural registers

## Operation
- Decode requires E_op == 6'b000000. Funct values: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- States: IDLE, BUSY. A 4-bit down-counter `cnt` and 64-bit result latch `res` are internal.
- IDLE, start: compute result from E_RS/E_RT at this edge and store it in `res`. Set cnt to MULT_CYCLES or DIV_CYCLES, then go to BUSY.
  - mult: `res` = signed 64-bit product. multu: unsigned product.
  - div: LO = $signed quotient truncated toward zero; HI = remainder with the dividend's sign. divu: unsigned quotient and remainder.
  - `res` = {HI_new, LO_new}.
- Divide by zero (E_RT == 0) on div/divu: the busy interval runs normally, but HI/LO are left unchanged at completion.
- BUSY: cnt decrements each edge. At the edge where cnt == 1: write HI/LO from `res` (unless the op was divide-by-zero), clear busy, return to IDLE.
- mthi/mtlo in E while IDLE: HI (resp. LO) <= E_RS at the edge.
- mfhi/mflo: read current registered HI/LO with no bypass.
- Any HI/LO instruction in E while BUSY is a pipeline-protocol violation and is ignored. The state machine and HI/LO do not change. The bench flags it as an assertion.
- Non-HI/LO instructions in E during BUSY proceed normally; the stall affects only D_md.

## Timing
- Reset values: state IDLE, cnt 0, `res` 0, HI 0, LO 0, E_MD_busy 0. Combinational outputs follow from these: E_MD_start and D_MD_stall follow inputs, and E_MD_out is 0.
- Start in cycle t: E_MD_busy is high in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO are updated at the edge ending cycle t+N. E_MD_busy is 0 in t+N+1.
- mfhi reaching E in t+N+1 reads the new value. D_MD_stall holds an mfhi in D through cycles t … t+N.
- Back-to-back starts: the earliest next start is cycle t+N+1. There are no idle bubbles beyond the stall.
- mthi/mtlo write visible to mfhi/mflo in E the following cycle.
- Reset asserted mid-BUSY: immediate return to IDLE with HI/LO = 0. No pending write survives reset deassertion.
- Counter width covers parameters up to 15.

## Test plan
- Reset, then mult with E_RS=0xFFFFFFFF, E_RT=2 → busy in cycles 1–5. HI=0xFFFFFFFF and LO=0xFFFFFFFE after cycle 5. mfhi in cycle 6 gives E_MD_out=0xFFFFFFFF.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div E_RS=-7 (0xFFFFFFF9), E_RT=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. divu 7/0 → HI/LO unchanged, busy still 10 cycles.
- D_md=1 held during a div → D_MD_stall=1 in the start cycle and all 10 busy cycles, and 0 in the following cycle.
- mthi 0x12345678, then mfhi next cycle → E_MD_out=0x12345678. mtlo 0xA5A5A5A5, then mflo → 0xA5A5A5A5.
- Assert reset in cycle 3 of a mult → busy=0 and HI=LO=0 immediately. After release, a new multu starts cleanly with correct results.

Source files
------------

// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: launches fixed-latency mult/div,
// owns HI/LO, serves mfhi/mflo and raises the D-stage stall while busy.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  E_op,
  input  logic [5:0]  E_fuc,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_md,
  output logic        E_MD_start,
  output logic        E_MD_busy,
  output logic [31:0] E_MD_out,
  output logic        D_MD_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt;
  logic [63:0] res;
  logic        dz;

  logic        is_special;
  logic        op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic        op_mul, op_div, op_muldiv;
  logic [3:0]  start_cnt;
  logic [63:0] res_d;

  logic signed [32:0] rs_s, rt_s, rt_nz, quot_s, rem_s;
  logic signed [63:0] rs_w, rt_w, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor_u, quot_u, rem_u;

  assign is_special = (E_op == 6'b000000);
  assign op_mfhi    = is_special && (E_fuc == F_MFHI);
  assign op_mthi    = is_special && (E_fuc == F_MTHI);
  assign op_mflo    = is_special && (E_fuc == F_MFLO);
  assign op_mtlo    = is_special && (E_fuc == F_MTLO);
  assign op_mul     = is_special && ((E_fuc == F_MULT) || (E_fuc == F_MULTU));
  assign op_div     = is_special && ((E_fuc == F_DIV) || (E_fuc == F_DIVU));
  assign op_muldiv  = op_mul || op_div;
  assign start_cnt  = op_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  assign E_MD_busy  = (state_q == BUSY);
  assign E_MD_start = (state_q == IDLE) && op_muldiv;
  assign D_MD_stall = D_md && (E_MD_start || E_MD_busy);

  always_comb begin
    E_MD_out = '0;
    if (op_mfhi)      E_MD_out = HI;
    else if (op_mflo) E_MD_out = LO;
  end

  // 33-bit signed divide keeps -2^31 / -1 well defined; a zero divisor is
  // replaced by 1 so the datapath never sees x/0 (the result is discarded).
  always_comb begin
    rs_s      = {E_RS[31], E_RS};
    rt_s      = {E_RT[31], E_RT};
    rt_nz     = (E_RT == '0) ? 33'sd1 : rt_s;
    quot_s    = rs_s / rt_nz;
    rem_s     = rs_s % rt_nz;
    divisor_u = (E_RT == '0) ? 32'd1 : E_RT;
    quot_u    = E_RS / divisor_u;
    rem_u     = E_RS % divisor_u;
    rs_w      = {{32{E_RS[31]}}, E_RS};
    rt_w      = {{32{E_RT[31]}}, E_RT};
    prod_s    = rs_w * rt_w;
    prod_u    = {32'b0, E_RS} * {32'b0, E_RT};
    res_d     = '0;
    case (E_fuc)
      F_MULT:  res_d = prod_s;
      F_MULTU: res_d = prod_u;
      F_DIV:   res_d = {32'(rem_s), 32'(quot_s)};
      F_DIVU:  res_d = {rem_u, quot_u};
      default: res_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (E_MD_start) state_d = BUSY;
      BUSY:    if (cnt == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      res <= '0;
      dz  <= 1'b0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_MD_start) begin
            res <= res_d;
            cnt <= start_cnt;
            dz  <= op_div && (E_RT == '0);
          end else if (op_mthi) begin
            HI <= E_RS;
          end else if (op_mtlo) begin
            LO <= E_RS;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if ((cnt == 4'd1) && !dz) begin
            HI <= res[63:32];
            LO <= res[31:0];
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
